// File: rtl/uart_pkg.sv
// Shared definitions for the UART datapath blocks.
//   clog2     : ceiling log2 for sizing pointers, counters and indices
//   ser_state_e : word serializer FSM encoding
//   BYTE_W    : width of one serial byte
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Evaluated at elaboration only; loop bound keeps it synthesizable.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO, DEPTH a power of two (>= 2).
//   clk, rst (async, active-high), ce (freezes all state when low)
//   push/din  : write request and data; ignored while full
//   pop       : read request; ignored while empty
//   dout      : head word, read through the registered read pointer
//   full/empty: derived from the registered occupancy count
module word_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;   // one extra bit so full and empty differ

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    // A full FIFO refuses writes even when a pop frees a slot this cycle.
    assign do_push = ce & push & ~full;
    assign do_pop  = ce & pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/word_serializer.sv
// Word-to-byte serializer for the UART transmit path.
//   clk, rst (async, active-high), ce (freezes all state when low)
//   word_valid/word_ready/word : upstream word handshake into the FIFO
//   byte_valid/byte_ready/byte_out/byte_last : registered byte stream,
//                                byte_last marks the final byte of a word
//   busy : FIFO holds a word or a word is being sent
module word_serializer
    import uart_pkg::*;
#(
    parameter int NBYTES     = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int MSB_FIRST  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     word_valid,
    output logic                     word_ready,
    input  logic [BYTE_W*NBYTES-1:0] word,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [BYTE_W-1:0]        byte_out,
    output logic                     byte_last,
    output logic                     busy
);

    localparam int WORD_W = BYTE_W * NBYTES;
    localparam int IW     = clog2(NBYTES);

    ser_state_e        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BYTE_W-1:0] byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              byte_last_q, byte_last_d;

    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic              last_idx;

    // Byte presented first from a word, and the word with that byte removed.
    function automatic logic [BYTE_W-1:0] head_byte(input logic [WORD_W-1:0] w);
        return (MSB_FIRST != 0) ? w[WORD_W-1 -: BYTE_W] : w[BYTE_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] drop_byte(input logic [WORD_W-1:0] w);
        return (MSB_FIRST != 0) ? (w << BYTE_W) : (w >> BYTE_W);
    endfunction

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .push  (word_valid & word_ready),
        .din   (word),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign last_idx   = (idx_q == IW'(NBYTES - 1));
    assign word_ready = ~fifo_full;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign byte_last  = byte_last_q;
    assign busy       = ~fifo_empty | (state_q == SEND);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shreg_q      <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            byte_last_q  <= byte_last_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (ce) begin
            case (state_q)
                IDLE:    if (!fifo_empty) state_d = SEND;
                SEND:    if (byte_ready && last_idx && fifo_empty) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath / outputs. Everything holds by default, which is what keeps
    // the byte stream stable while the UART back-pressures.
    always_comb begin
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        byte_last_d  = byte_last_q;
        fifo_pop     = 1'b0;
        if (ce) begin
            if ((state_q == IDLE && !fifo_empty) ||
                (state_q == SEND && byte_ready && last_idx && !fifo_empty)) begin
                // Load the head word; back-to-back when already sending.
                fifo_pop     = 1'b1;
                idx_d        = '0;
                byte_valid_d = 1'b1;
                byte_last_d  = (NBYTES == 1);
                byte_out_d   = head_byte(fifo_dout);
                shreg_d      = drop_byte(fifo_dout);
            end else if (state_q == SEND && byte_ready && !last_idx) begin
                idx_d        = idx_q + 1'b1;
                byte_valid_d = 1'b1;
                byte_last_d  = (idx_q == IW'(NBYTES - 2));
                byte_out_d   = head_byte(shreg_q);
                shreg_d      = drop_byte(shreg_q);
            end else if (state_q == SEND && byte_ready) begin
                // Final byte taken and nothing queued.
                idx_d        = '0;
                byte_valid_d = 1'b0;
                byte_out_d   = '0;
                byte_last_d  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        rst, ce;

    // 2-byte, LSB-first instance
    logic        wv2, wr2, bv2, br2, bl2, busy2;
    logic [15:0] w2;
    logic [7:0]  bo2;

    // 4-byte, MSB-first instance
    logic        wv4, wr4, bv4, br4, bl4, busy4;
    logic [31:0] w4;
    logic [7:0]  bo4;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    word_serializer #(.NBYTES(2), .FIFO_DEPTH(2), .MSB_FIRST(0)) dut2 (
        .clk(clk), .rst(rst), .ce(ce),
        .word_valid(wv2), .word_ready(wr2), .word(w2),
        .byte_valid(bv2), .byte_ready(br2), .byte_out(bo2),
        .byte_last(bl2), .busy(busy2)
    );

    word_serializer #(.NBYTES(4), .FIFO_DEPTH(2), .MSB_FIRST(1)) dut4 (
        .clk(clk), .rst(rst), .ce(ce),
        .word_valid(wv4), .word_ready(wr4), .word(w4),
        .byte_valid(bv4), .byte_ready(br4), .byte_out(bo4),
        .byte_last(bl4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string tag, input logic v, input logic [7:0] b, input logic l);
        chk({tag, "_v"}, bv2, v);
        chk({tag, "_b"}, bo2, b);
        chk({tag, "_l"}, bl2, l);
    endtask

    logic [7:0] e4 [8];
    logic [7:0] l4;

    initial begin
        rst = 1'b1; ce = 1'b1;
        wv2 = 0; w2 = '0; br2 = 0;
        wv4 = 0; w4 = '0; br4 = 0;
        tick();
        chk2("rst", 0, 8'h00, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_wr", wr2, 1);
        chk("rst4_v", bv4, 0);
        chk("rst4_wr", wr4, 1);
        rst = 1'b0;
        tick();

        // LSB-first word, no bypass path
        wv2 = 1; w2 = 16'hA55A; br2 = 1;
        tick();
        wv2 = 0;
        chk("t1_nobypass", bv2, 0);
        chk("t1_busy", busy2, 1);
        tick(); chk2("t1_b0", 1, 8'h5A, 0);
        tick(); chk2("t1_b1", 1, 8'hA5, 1);
        tick(); chk2("t1_idle", 0, 8'h00, 0);
        chk("t1_busy_end", busy2, 0);

        // MSB-first, two words back-to-back with no gap
        e4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        l4 = 8'b1000_1000;   // bit i: byte i is last
        wv4 = 1; w4 = 32'h11223344; br4 = 1;
        tick();
        w4 = 32'hAABBCCDD;
        tick();
        wv4 = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk($sformatf("t2_v%0d", i), bv4, 1);
            chk($sformatf("t2_b%0d", i), bo4, e4[i]);
            chk($sformatf("t2_l%0d", i), bl4, l4[i]);
        end
        tick();
        chk("t2_idle", bv4, 0);
        chk("t2_busy", busy4, 0);

        // Backpressure holds the byte stable
        wv2 = 1; w2 = 16'hA55A; br2 = 0;
        tick();
        wv2 = 0;
        tick(); chk2("t3_first", 1, 8'h5A, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk2($sformatf("t3_hold%0d", i), 1, 8'h5A, 0);
        end
        br2 = 1;
        tick(); chk2("t3_next", 1, 8'hA5, 1);
        tick(); chk2("t3_idle", 0, 8'h00, 0);

        // Full FIFO: 1 word in shifter + 2 in FIFO, 4th waits
        br2 = 0; wv2 = 1;
        w2 = 16'h0102; chk("t4_wr1", wr2, 1); tick();
        w2 = 16'h0304; chk("t4_wr2", wr2, 1); tick();
        w2 = 16'h0506; chk("t4_wr3", wr2, 1); tick();
        w2 = 16'h0708; chk("t4_wr4", wr2, 0); tick();
        chk("t4_wr4b", wr2, 0);
        chk2("t4_held", 1, 8'h02, 0);
        br2 = 1;
        tick(); chk2("t4_a", 1, 8'h01, 1); chk("t4_wr_a", wr2, 0);
        tick(); chk2("t4_b", 1, 8'h04, 0); chk("t4_wr_b", wr2, 1);
        tick(); chk2("t4_c", 1, 8'h03, 1); chk("t4_wr_c", wr2, 0);
        wv2 = 0;
        tick(); chk2("t4_d", 1, 8'h06, 0);
        tick(); chk2("t4_e", 1, 8'h05, 1);
        tick(); chk2("t4_f", 1, 8'h08, 0);
        tick(); chk2("t4_g", 1, 8'h07, 1);
        tick(); chk2("t4_idle", 0, 8'h00, 0);
        chk("t4_busy", busy2, 0);

        // ce low freezes outputs and blocks handshakes
        wv2 = 1; w2 = 16'hBEEF; br2 = 1;
        tick();
        wv2 = 0;
        tick(); chk2("t5_first", 1, 8'hEF, 0);
        ce = 0; wv2 = 1; w2 = 16'h1111;
        tick(); chk2("t5_frz0", 1, 8'hEF, 0); chk("t5_wr0", wr2, 1);
        tick(); chk2("t5_frz1", 1, 8'hEF, 0);
        ce = 1; wv2 = 0;
        tick(); chk2("t5_next", 1, 8'hBE, 1);
        tick(); chk2("t5_idle", 0, 8'h00, 0);
        chk("t5_busy", busy2, 0);

        // Asynchronous reset mid-word discards the rest of it
        wv2 = 1; w2 = 16'h1234; br2 = 0;
        tick();
        wv2 = 0;
        tick(); chk2("t6_first", 1, 8'h34, 0);
        rst = 1;
        #2;
        chk2("t6_async", 0, 8'h00, 0);
        chk("t6_busy", busy2, 0);
        chk("t6_wr", wr2, 1);
        br2 = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk2($sformatf("t6_after%0d", i), 0, 8'h00, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parametrised word-to-byte serializer for the UART transmit path. It accepts words of `NBYTES` bytes through a valid/ready handshake and buffers them in a small word FIFO. It emits them one byte at a time, in either byte order, through a ready/valid byte stream that the UART transmitter back-pressures. This block replaces the fixed 16-bit, two-cycle word splitter: it adds configurable width, buffering, endianness and true downstream flow control.

## Interface
- `NBYTES`, default 2: bytes per word, 2..8; word width is `8*NBYTES`.
- `FIFO_DEPTH`, default 2: word FIFO depth, power of two, ≥2.
- `MSB_FIRST`, default 0: 0 sends the least-significant byte first; 1 sends the most-significant byte first.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ce`  in  1  clock enable; when 0, all state freezes and no handshake completes.
- `word_valid`  in  1  upstream word present.
- `word_ready`  out  1  equals `!fifo_full` (combinational from the registered count).
- `word`  in  `8*NBYTES`  word data; sampled on accept.
- `byte_valid`  out  1  `byte_out` is valid; registered.
- `byte_ready`  in  1  downstream accepts the byte (UART tx not busy).
- `byte_out`  out  8  current byte; registered; 0 whenever `byte_valid`=0.
- `byte_last`  out  1  high with the final byte of each word; registered.
- `busy`  out  1  FIFO non-empty or serializer in SEND.

## Operation
- Word accept: on an edge with `ce & word_valid & word_ready`; the word is written to the FIFO.
- No write occurs when the FIFO is full, even if a pop happens in the same cycle.
- Serializer FSM has two states, IDLE and SEND, plus a byte index `idx` of width `clog2(NBYTES)` and a word shift register.
- IDLE, with `ce` and FIFO non-empty:
  - pop the head word;
  - drive byte 0 (per `MSB_FIRST`) with `byte_valid`=1;
  - `byte_last` = (NBYTES==1 ? 1 : 0);
  - `idx`=0; go to SEND.
- SEND, with `ce & byte_ready` and `idx` < NBYTES-1: `idx`+1, drive the next byte, and set `byte_last` when the new `idx`=NBYTES-1.
- SEND, with `ce & byte_ready` and `idx`=NBYTES-1:
  - if the FIFO is non-empty, pop and load the next word back-to-back, with no idle cycle;
  - otherwise `byte_valid`=0, `byte_out`=0, `byte_last`=0, and go to IDLE.
- SEND without `byte_ready`: `byte_out`, `byte_valid` and `byte_last` hold stable, as the valid/ready rule requires.
- Simultaneous FIFO push and pop: both take effect; the count is unchanged.
- Reset (any time, including mid-word):
  - FIFO is flushed (pointers and count = 0);
  - FSM = IDLE, `idx`=0;
  - `byte_valid`=0, `byte_out`=0, `byte_last`=0, `busy`=0;
  - `word_ready`=1.
- A partially sent word is discarded on reset.
- Pointer wrap-around is modulo `FIFO_DEPTH`. The count has width `clog2(FIFO_DEPTH)+1` so that full and empty are distinguishable.

## Timing
- Latency: a word accepted at edge k with the FIFO empty and FSM in IDLE gives `byte_valid`=1 after edge k+1. There is no bypass path.
- Throughput: with `byte_ready` held at 1 and `ce`=1, one byte per cycle, continuous across words.
- Each word spends exactly NBYTES byte-handshakes in SEND.
- Storage: total words held = FIFO_DEPTH in the FIFO + 1 in the shifter.
- Cycles with `ce`=0 do not count. No output changes on those cycles, except `word_ready`, which stays constant because the count is frozen.

## Structure
- Package `uart_pkg`:
  - `clog2` function;
  - serializer state enum (IDLE, SEND);
  - byte-width constant `BYTE_W`=8.
- Sub-module `word_fifo`: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, rst, ce, push, din, pop, dout (head, registered-pointer read), full, empty.
  - Reused elsewhere in the UART receive path.
- Top level: FIFO instance, FSM, index counter, shifter and output registers.

## Test plan
- LSB-first word, NBYTES=2, MSB_FIRST=0, `byte_ready`=1: push 0xA55A → bytes 0x5A then 0xA5 on consecutive cycles, `byte_last`=1 only on 0xA5, first byte one cycle after accept.
- MSB-first word, NBYTES=4, MSB_FIRST=1: push 0x11223344 and 0xAABBCCDD back-to-back → bytes 11,22,33,44,AA,BB,CC,DD with no gap; `byte_last` high on 44 and DD.
- Backpressure: hold `byte_ready`=0 for 3 cycles while 0x5A is presented → `byte_out`=0x5A and `byte_valid`=1 stable throughout; 0xA5 follows one cycle after `byte_ready` rises.
- Full FIFO, FIFO_DEPTH=2, `byte_ready`=0: offer 4 words → 3 accepted (1 in shifter, 2 in FIFO), `word_ready`=0 on the 4th. One completed word with a simultaneous offer gives the 4th accepted; all bytes come out in order.
- ce gating and reset: pulse `ce`=0 for 2 cycles mid-word → outputs frozen, no handshakes. Assert `rst` after the first byte of 0x1234 → `byte_valid`=0, `byte_out`=0, `busy`=0 immediately, and 0x12 is never emitted.
